// File: rtl/uart_tx_arbiter.sv
// Message-granular two-requester arbiter in front of a single UART TX, with a
// one-entry output register. Optional owner-idle timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter logic [7:0]  EOL     = 8'h0A,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_a_valid,
    input  logic [7:0] i_a_data,
    output logic       o_a_ready,
    input  logic       i_b_valid,
    input  logic [7:0] i_b_data,
    output logic       o_b_ready,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic [1:0] o_grant
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be in 2..65535");
    end

    state_e     state_q, state_d;
    logic       last_q, last_d;          // 0 = A, 1 = B owned most recently
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       slot_free, own_valid, accept, timeout_hit;
    logic [7:0] own_data;

    assign slot_free  = !tx_valid_q || i_tx_ready;
    assign o_a_ready  = (state_q == OWN_A) && slot_free;
    assign o_b_ready  = (state_q == OWN_B) && slot_free;
    assign accept     = (o_a_ready && i_a_valid) || (o_b_ready && i_b_valid);
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_grant    = {state_q == OWN_B, state_q == OWN_A};

    always_comb begin
        own_valid = 1'b0;
        own_data  = i_a_data;
        case (state_q)
            OWN_A:   begin own_valid = i_a_valid; own_data = i_a_data; end
            OWN_B:   begin own_valid = i_b_valid; own_data = i_b_data; end
            default: ;
        endcase
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = 16'd0;
        if (state_q != IDLE && !own_valid) idle_cnt_d = idle_cnt_q + 16'd1;
    end

    assign timeout_hit = (state_q != IDLE) && !own_valid && (idle_cnt_q == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) idle_cnt_q <= 16'd0;
        else          idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A is preferred in IDLE unless it was the last owner and B also waits.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_a_valid && (!i_b_valid || last_q)) state_d = OWN_A;
                else if (i_b_valid)                      state_d = OWN_B;
            end
            default: begin
                if ((accept && own_data == EOL) || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = (state_q == OWN_B);
                end
            end
        endcase
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end else if (tx_valid_q && i_tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: bytes are queued when a handshake is
// seen and popped when the transmitter takes them.
module tb_uart_tx_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_a_valid, i_b_valid, i_tx_ready;
    logic [7:0] i_a_data, i_b_data;
    logic       o_a_ready, o_b_ready, o_tx_valid;
    logic [7:0] o_tx_data;
    logic [1:0] o_grant;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         acc_log[$];

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(.EOL(8'h0A), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .o_grant(o_grant)
    );

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_tx_valid && i_tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %02h, required no byte", o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_tx_data !== e) begin
                        errors++;
                        $display("FAIL sb_data: got %02h, required %02h", o_tx_data, e);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        i_a_data = 8'h00; i_b_data = 8'h00;
        i_tx_ready = 1'b1;
        acc_log.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic send(input bit port, input logic [7:0] bytes[$]);
        int n;
        foreach (bytes[i]) begin
            n = 0;
            if (port) begin i_b_valid = 1'b1; i_b_data = bytes[i]; end
            else      begin i_a_valid = 1'b1; i_a_data = bytes[i]; end
            forever begin
                @(negedge i_clk);
                if (port ? o_b_ready : o_a_ready) begin
                    exp_q.push_back(bytes[i]);
                    acc_log.push_back(port);
                    break;
                end
                n++;
                if (n > 60) begin
                    checks++; errors++;
                    $display("FAIL send_wait: port %0d byte %02h got no ready in %0d cycles, required ready", port, bytes[i], n);
                    break;
                end
            end
            @(posedge i_clk); #1;
        end
        if (port) i_b_valid = 1'b0;
        else      i_a_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_a_valid = 1'b1; i_b_valid = 1'b1;
        i_a_data = 8'h0A; i_b_data = 8'h0A;
        i_tx_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", o_tx_valid); end
        checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", o_tx_data); end
        checks++; if ({o_a_ready, o_b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, required 00", {o_a_ready, o_b_ready}); end
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, required 00", o_grant); end
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_single();
        logic [7:0] bytes [3];
        bytes = '{8'h48, 8'h69, 8'h0A};
        do_reset();
        i_a_valid = 1'b1; i_a_data = bytes[0];
        @(negedge i_clk);
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL single_pregrant: got %b, required 00", o_grant); end
        checks++; if (o_a_ready !== 1'b0) begin errors++; $display("FAIL single_idle_ready: got %b, required 0", o_a_ready); end
        @(posedge i_clk); #1;
        for (int i = 0; i < 3; i++) begin
            i_a_data = bytes[i];
            @(negedge i_clk);
            checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_grant: byte %0d got %b, required 01", i, o_grant); end
            checks++; if (o_a_ready !== 1'b1) begin errors++; $display("FAIL single_ready: byte %0d got %b, required 1", i, o_a_ready); end
            if (i > 0) begin
                checks++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== bytes[i-1]) begin
                    errors++; $display("FAIL single_tx: got %b/%02h, required 1/%02h", o_tx_valid, o_tx_data, bytes[i-1]);
                end
            end
            if (o_a_ready) exp_q.push_back(bytes[i]);
            @(posedge i_clk); #1;
        end
        i_a_valid = 1'b0;
        @(negedge i_clk);
        checks++; if (o_tx_data !== 8'h0A || o_tx_valid !== 1'b1) begin errors++; $display("FAIL single_eol_tx: got %b/%02h, required 1/0a", o_tx_valid, o_tx_data); end
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b, required 00", o_grant); end
    endtask

    task automatic test_contention();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [31:0] ord;
        qa = '{8'h41, 8'h42, 8'h0A};
        qb = '{8'h61, 8'h62, 8'h0A};
        do_reset();
        fork
            send(1'b0, qa);
            send(1'b1, qb);
        join
        ord = '0;
        foreach (acc_log[i]) ord[i] = acc_log[i];
        checks++; if (acc_log.size() != 6) begin errors++; $display("FAIL contention_count: got %0d, required 6", acc_log.size()); end
        checks++; if (ord !== 32'h38) begin errors++; $display("FAIL contention_order: got %h, required 00000038", ord); end
    endtask

    task automatic test_fairness();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [31:0] ord;
        qa = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A};
        qb = '{8'h61, 8'h62, 8'h0A};
        do_reset();
        fork
            send(1'b0, qa);
            send(1'b1, qb);
        join
        ord = '0;
        foreach (acc_log[i]) ord[i] = acc_log[i];
        checks++; if (acc_log.size() != 9) begin errors++; $display("FAIL fairness_count: got %0d, required 9", acc_log.size()); end
        checks++; if (ord !== 32'h38) begin errors++; $display("FAIL fairness_order: got %h, required 00000038", ord); end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_a_valid = 1'b1; i_a_data = 8'h11;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++; if (o_a_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b, required 1", o_a_ready); end
        if (o_a_ready) exp_q.push_back(8'h11);
        @(posedge i_clk); #1;
        i_a_data = 8'h22; i_tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h11) begin errors++; $display("FAIL bp_hold: cycle %0d got %b/%02h, required 1/11", c, o_tx_valid, o_tx_data); end
            checks++; if ({o_a_ready, o_b_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready: cycle %0d got %b, required 00", c, {o_a_ready, o_b_ready}); end
            @(posedge i_clk); #1;
        end
        i_tx_ready = 1'b1;
        @(negedge i_clk);
        checks++; if (o_a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b, required 1", o_a_ready); end
        if (o_a_ready) exp_q.push_back(8'h22);
        @(posedge i_clk); #1;
        i_a_data = 8'h0A;
        @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h22) begin errors++; $display("FAIL bp_swap: got %b/%02h, required 1/22", o_tx_valid, o_tx_data); end
        if (o_a_ready) exp_q.push_back(8'h0A);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int  idle_at, b_at;
        bit  b_sent;
        do_reset();
        i_a_valid = 1'b1; i_a_data = 8'h41;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        if (o_a_ready) exp_q.push_back(8'h41);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        i_b_valid = 1'b1; i_b_data = 8'h0A;
        idle_at = -1; b_at = -1; b_sent = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge i_clk);
            if (o_grant == 2'b00 && idle_at < 0) idle_at = c;
            if (o_grant == 2'b10 && b_at < 0)    b_at = c;
            if (o_b_ready && !b_sent) begin exp_q.push_back(8'h0A); b_sent = 1'b1; end
            @(posedge i_clk); #1;
            if (b_sent) i_b_valid = 1'b0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        checks++; if (idle_at != 5) begin errors++; $display("FAIL timeout_release: idle at cycle %0d, required 5", idle_at); end
        checks++; if (b_at != 6) begin errors++; $display("FAIL timeout_regrant: B granted at cycle %0d, required 6", b_at); end
`else
        checks++; if (idle_at != -1) begin errors++; $display("FAIL no_timeout_release: idle at cycle %0d, required never", idle_at); end
        checks++; if (b_at != -1) begin errors++; $display("FAIL no_timeout_starve: B granted at cycle %0d, required never", b_at); end
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL no_timeout_owner: got %b, required 01", o_grant); end
`endif
        i_b_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        i_tx_ready = 1'b0;
        i_a_valid = 1'b1; i_a_data = 8'h55;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        if (o_a_ready) exp_q.push_back(8'h55);
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        checks++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h55) begin errors++; $display("FAIL async_pre: got %b/%02h, required 1/55", o_tx_valid, o_tx_data); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin errors++; $display("FAIL async_tx: got %b/%02h, required 0/00", o_tx_valid, o_tx_data); end
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL async_grant: got %b, required 00", o_grant); end
        checks++; if ({o_a_ready, o_b_ready} !== 2'b00) begin errors++; $display("FAIL async_ready: got %b, required 00", {o_a_ready, o_b_ready}); end
        exp_q.delete();
        i_a_valid = 1'b1; i_b_valid = 1'b1;
        i_a_data = 8'h31; i_b_data = 8'h32;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL async_tie: got %b, required 01", o_grant); end
        @(posedge i_clk); #1;
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        do_reset();
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        i_a_data = 8'h00; i_b_data = 8'h00;
        i_tx_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_async_reset();
        repeat (5) @(posedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d bytes undelivered, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single serial TX transmitter (the UART driving the board's TX pad) between two byte-stream requesters: the CPU console (port A) and a debug/status reporter (port B). Grants are message-granular. A requester keeps ownership until it sends an end-of-line byte, so lines from the two sources never interleave. A one-entry output register sits between the granted requester and the transmitter's valid/ready input.

## Interface
Parameters:
- `EOL`, 8'h0A: terminator byte; its transfer releases the grant.
- `TIMEOUT`, 1024: idle cycles by the owner before forced release (used only with `UART_ARB_TIMEOUT_EN`); legal range 2..65535.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_a_valid`  in  1  requester A has a byte.
- `i_a_data`  in  8  requester A byte.
- `o_a_ready`  out  1  requester A byte accepted this cycle when `i_a_valid` is also high.
- `i_b_valid`, `i_b_data`, `o_b_ready`: same as A, for requester B.
- `o_tx_valid`  out  1  output register holds a byte.
- `o_tx_data`  out  8  byte to the transmitter.
- `i_tx_ready`  in  1  transmitter accepts `o_tx_data` when `o_tx_valid` is high.
- `o_grant`  out  2  one-hot owner: bit0 = A, bit1 = B; 2'b00 when idle.

## Operation
- States:
  - `IDLE`: no owner.
  - `OWN_A`: A owns the transmitter.
  - `OWN_B`: B owns the transmitter.
- Round-robin pointer `last` records the most recent owner.
- `IDLE` transitions:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not `last`.
  - Neither valid: stay in `IDLE`.
  - The grant is registered. No byte is accepted in `IDLE`.
- Ready:
  - `o_X_ready = (state == OWN_X) && (!o_tx_valid || i_tx_ready)`.
  - The ready of the non-owner is always 0.
- On accept (owner valid and ready): load the byte into the output register and set `o_tx_valid`.
- On drain (`o_tx_valid && i_tx_ready`) with no load in the same cycle: clear `o_tx_valid`.
- Simultaneous drain and load: the register takes the new byte and `o_tx_valid` stays 1. Throughput is one byte per cycle.
- Accepting a byte equal to `EOL`:
  - Next state is `IDLE` and `last` becomes the owner.
  - The `EOL` byte itself is still transferred to the output register.
- The output register drains independently of the state. A new owner's first byte may wait behind the previous owner's last byte.
- Data widths are fixed at 8 bits. There is no arithmetic on data.

## Timing
- Reset values:
  - `o_tx_valid` = 0, `o_tx_data` = 8'h00.
  - `o_a_ready` = `o_b_ready` = 0, `o_grant` = 2'b00.
  - State = `IDLE`, `last` = B, so A wins the first tie.
  - Timeout counter = 0.
- Grant latency: a request seen in `IDLE` at cycle N gives `o_grant` set at N+1. The first byte is accepted at N+1 at the earliest.
- Release latency: `EOL` accepted at cycle M gives `o_grant` = 00 at M+1. The next grant is at M+2 at the earliest. There are no back-to-back grants without an `IDLE` cycle.
- Accept-to-output latency: one cycle. `o_tx_valid`/`o_tx_data` update on the clock edge of acceptance.
- Backpressure: while `o_tx_valid && !i_tx_ready`, `o_tx_data` is held stable and both readies are 0.
- Reset mid-operation: reset is asynchronous and takes effect immediately. Any buffered byte is discarded and ownership is dropped.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter increments each cycle the state is `OWN_X` and `i_X_valid` is 0.
  - The counter clears to 0 when `i_X_valid` is 1 or the state is `IDLE`.
  - When the count reaches `TIMEOUT - 1`, the next state is `IDLE` and `last` becomes the owner. This is the same as an `EOL` release, and no byte is dropped.
- Not defined:
  - No counter is built and `TIMEOUT` is ignored.
  - Ownership is released only by `EOL` or by reset. A requester that never sends `EOL` starves the other one.

## Test plan
- Single requester: A sends 8'h48, 8'h69, 8'h0A with `i_tx_ready` = 1 → `o_grant` = 01 one cycle after valid. `o_tx_data` shows 48, 69, 0A on consecutive cycles. `o_grant` = 00 the cycle after 0A is accepted.
- Contention from reset: A and B both valid in the same cycle, each sending a 3-byte line ending in 0A → A's full line first, one `IDLE` cycle, then B's full line. No interleaving.
- Fairness: A re-requests immediately after its 0A while B is pending → B is granted next. A is granted after B's 0A.
- Backpressure: hold `i_tx_ready` = 0 for 5 cycles with a byte buffered → `o_tx_data` is stable, `o_a_ready` = 0 throughout. On release, the byte drains and the next byte loads in the same cycle.
- Timeout (`UART_ARB_TIMEOUT_EN`, `TIMEOUT` = 4): A sends 8'h41 with no 0A, then drops valid; B is valid → `o_grant` = 00 four idle cycles later, then 10. 8'h41 is still delivered. Without the macro, B is never granted within 100 cycles.
- Async reset: assert `i_rst_n` = 0 mid-line with `o_tx_valid` = 1 → all outputs are 0 immediately, without waiting for a clock edge. After release, A wins a simultaneous request.
